// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES core arbiter.
// Imported by the arbiter top and its round-robin picker.
package aes_arb_pkg;

   localparam int AES_W       = 128;
   localparam int DEF_TIMEOUT = 1024;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_BUSY,
      S_DELIVER,
      S_CLEAR
   } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit
// at or after rr_ptr_i, wrapping modulo N.
module rr_pick
   import aes_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] rr_ptr_i,
   output logic          valid_o,
   output logic [IW-1:0] index_o
);

   int j;

   always_comb begin
      valid_o = 1'b0;
      index_o = '0;
      j       = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(rr_ptr_i) + i;
         if (j >= N) j = j - N;
         if (!valid_o && req_i[j[IW-1:0]]) begin
            valid_o = 1'b1;
            index_o = j[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/aes_arbiter.sv
// Shares one AES core among N requesters: round-robin grant,
// one Run pulse, watchdog, done/ack delivery, core reset.
module aes_arbiter
   import aes_arb_pkg::*;
#(
   parameter int N       = 2,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CW      = 11
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N-1:0]       req,
   input  logic [N*AES_W-1:0] msg_in,
   input  logic [N*AES_W-1:0] key_in,
   input  logic [N-1:0]       ack,
   output logic [N-1:0]       done,
   output logic [AES_W-1:0]   result,
   output logic               busy,
   output logic               timeout_err,
   output logic               core_reset,
   output logic               core_run,
   output logic [AES_W-1:0]   core_plaintext,
   output logic [AES_W-1:0]   core_key,
   input  logic [AES_W-1:0]   core_ciphertext,
   input  logic               core_ready
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   state_e            state_q, state_d;
   logic [IW-1:0]     rr_q, rr_d;
   logic [IW-1:0]     g_q, g_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [AES_W-1:0]  res_q, res_d;
   logic [AES_W-1:0]  pt_q, pt_d;
   logic [AES_W-1:0]  key_q, key_d;

   logic              pick_valid;
   logic [IW-1:0]     pick_idx;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req_i    (req),
      .rr_ptr_i (rr_q),
      .valid_o  (pick_valid),
      .index_o  (pick_idx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         g_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         pt_q    <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         g_q     <= g_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         pt_q    <= pt_d;
         key_q   <= key_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      g_d         = g_q;
      cnt_d       = cnt_q;
      res_d       = res_q;
      pt_d        = pt_q;
      key_d       = key_q;
      timeout_err = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pick_valid) begin
               g_d     = pick_idx;
               pt_d    = msg_in[pick_idx*AES_W +: AES_W];
               key_d   = key_in[pick_idx*AES_W +: AES_W];
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_BUSY;
         end
         S_BUSY: begin
            cnt_d = cnt_q + CW'(1);
            // A ready core beats the watchdog on the same cycle.
            if (core_ready) begin
               res_d   = core_ciphertext;
               state_d = S_DELIVER;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               timeout_err = 1'b1;
               state_d     = S_CLEAR;
            end
         end
         S_DELIVER: begin
            if (ack[g_q]) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            if (g_q == IW'(N - 1)) rr_d = '0;
            else                   rr_d = g_q + IW'(1);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      done = '0;
      if (state_q == S_DELIVER) done[g_q] = 1'b1;
   end

   assign result         = res_q;
   assign busy           = (state_q != S_IDLE);
   assign core_run       = (state_q == S_LAUNCH);
   assign core_reset     = ~reset_n | (state_q == S_CLEAR);
   assign core_plaintext = pt_q;
   assign core_key       = key_q;

endmodule

// File: tb/tb_aes_arbiter.sv
// Directed bench for aes_arbiter with a latency-programmable stub core.
module tb_aes_arbiter;

   localparam int N = 2;
   localparam logic [127:0] PT_V = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KY_V = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_V = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N-1:0]   req;
   logic [255:0]   msg_in;
   logic [255:0]   key_in;
   logic [N-1:0]   ack;
   logic [N-1:0]   done;
   logic [127:0]   result;
   logic           busy;
   logic           timeout_err;
   logic           core_reset;
   logic           core_run;
   logic [127:0]   core_plaintext;
   logic [127:0]   core_key;
   logic [127:0]   core_ciphertext;
   logic           core_ready;

   int n_cmp = 0;
   int n_err = 0;
   int stub_lat = 3;
   bit stub_never = 1'b0;
   bit to_seen = 1'b0;
   int run_cnt = 0;
   int rst_cnt = 0;
   int s_cnt;
   bit s_run;

   always #5 clk = ~clk;

   aes_arbiter #(.N(N), .TIMEOUT(16), .CW(5)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .req             (req),
      .msg_in          (msg_in),
      .key_in          (key_in),
      .ack             (ack),
      .done            (done),
      .result          (result),
      .busy            (busy),
      .timeout_err     (timeout_err),
      .core_reset      (core_reset),
      .core_run        (core_run),
      .core_plaintext  (core_plaintext),
      .core_key        (core_key),
      .core_ciphertext (core_ciphertext),
      .core_ready      (core_ready)
   );

   // Stub core: known FIPS-197 vector, otherwise plaintext ^ key.
   assign core_ciphertext =
      (core_plaintext == PT_V && core_key == KY_V) ? CT_V
                                                    : core_plaintext ^ core_key;

   always @(posedge clk) begin
      if (core_reset) begin
         s_run      <= 1'b0;
         s_cnt      <= 0;
         core_ready <= 1'b0;
      end else if (core_run) begin
         s_run <= 1'b1;
         s_cnt <= 1;
      end else if (s_run && !core_ready && !stub_never) begin
         if (s_cnt >= stub_lat) core_ready <= 1'b1;
         s_cnt <= s_cnt + 1;
      end
   end

   always @(posedge clk) begin
      if (reset_n) begin
         if (core_run)   run_cnt <= run_cnt + 1;
         if (core_reset) rst_cnt <= rst_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // which: 0 = any done, 1 = core_run, 2 = timeout_err
   task automatic wait_for(input int which, input int budget, output int k);
      k = -1;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (timeout_err) to_seen = 1'b1;
         if ((which == 0 && done != '0) ||
             (which == 1 && core_run) ||
             (which == 2 && timeout_err)) begin
            k = c;
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      int r0;
      int q0;
      int stable;
      logic [1:0] exp_oh;
      logic [127:0] exp_res;
      logic [127:0] exp_pt;

      reset_n = 1'b0;
      req     = '0;
      ack     = '0;
      msg_in  = '0;
      key_in  = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_done", 128'(done), 128'(2'b00));
      chk("rst_result", result, '0);
      chk("rst_busy", 128'(busy), 128'(1'b0));
      chk("rst_core_reset", 128'(core_reset), 128'(1'b1));
      chk("rst_core_run", 128'(core_run), 128'(1'b0));
      chk("rst_timeout", 128'(timeout_err), 128'(1'b0));
      chk("rst_pt", core_plaintext, '0);
      chk("rst_key", core_key, '0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_core_reset", 128'(core_reset), 128'(1'b0));

      // Single requester 0, known vector, latency stub 3.
      r0 = run_cnt;
      q0 = rst_cnt;
      msg_in[127:0] = PT_V;
      key_in[127:0] = KY_V;
      req = 2'b01;
      wait_for(0, 50, k);
      chk("t1_latency", 128'(k), 128'(6));
      chk("t1_done", 128'(done), 128'(2'b01));
      chk("t1_result", result, CT_V);
      chk("t1_pt", core_plaintext, PT_V);
      chk("t1_key", core_key, KY_V);
      ack = 2'b01;
      @(negedge clk);
      chk("t1_done_drop", 128'(done), 128'(2'b00));
      chk("t1_clear", 128'(core_reset), 128'(1'b1));
      ack = 2'b00;
      req = 2'b00;
      @(negedge clk);
      chk("t1_idle", 128'(busy), 128'(1'b0));
      chk("t1_runs", 128'(run_cnt - r0), 128'(1));
      chk("t1_resets", 128'(rst_cnt - q0), 128'(1));

      // Both requesting: rr_ptr is 1 after the last grant to 0.
      stub_lat = 5;
      msg_in = {{16{8'h50}}, {16{8'hA0}}};
      key_in = {{16{8'h05}}, {16{8'h0F}}};
      req = 2'b11;
      for (int it = 0; it < 4; it++) begin
         exp_oh  = (it % 2 == 0) ? 2'b10 : 2'b01;
         exp_res = (it % 2 == 0) ? {16{8'h55}} : {16{8'hAF}};
         exp_pt  = (it % 2 == 0) ? {16{8'h50}} : {16{8'hA0}};
         wait_for(0, 50, k);
         chk("t2_grant", 128'(done), 128'(exp_oh));
         chk("t2_result", result, exp_res);
         chk("t2_pt", core_plaintext, exp_pt);
         ack = 2'b11;
         @(negedge clk);
         chk("t2_done_drop", 128'(done), 128'(2'b00));
         chk("t2_clear", 128'(core_reset), 128'(1'b1));
         ack = 2'b00;
         @(negedge clk);
         chk("t2_turnaround", 128'(busy), 128'(1'b0));
         if (it == 3) req = 2'b00;
      end
      @(negedge clk);

      // Delayed ack, inputs changed and req dropped mid-operation.
      msg_in[127:0] = {16{8'hC3}};
      key_in[127:0] = {16{8'h3C}};
      req = 2'b01;
      wait_for(1, 20, k);
      chk("t3_run", 128'(core_run), 128'(1'b1));
      req = 2'b00;
      wait_for(0, 50, k);
      chk("t3_done", 128'(done), 128'(2'b01));
      chk("t3_result", result, {16{8'hFF}});
      msg_in[127:0] = {16{8'h99}};
      key_in[127:0] = {16{8'h77}};
      ack = 2'b10;
      stable = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (done === 2'b01 && result === {16{8'hFF}} &&
             core_plaintext === {16{8'hC3}}) stable++;
      end
      chk("t3_stable", 128'(stable), 128'(50));
      ack = 2'b01;
      @(negedge clk);
      chk("t3_done_drop", 128'(done), 128'(2'b00));
      ack = 2'b00;
      @(negedge clk);

      // Watchdog: core never ready, TIMEOUT 16.
      stub_never = 1'b1;
      req = 2'b10;
      wait_for(1, 20, k);
      chk("t4_run", 128'(core_run), 128'(1'b1));
      wait_for(2, 40, k);
      chk("t4_to_dist", 128'(k), 128'(16));
      chk("t4_no_done", 128'(done), 128'(2'b00));
      chk("t4_retained", result, {16{8'hFF}});
      req = 2'b00;
      @(negedge clk);
      chk("t4_clear", 128'(core_reset), 128'(1'b1));
      chk("t4_pulse", 128'(timeout_err), 128'(1'b0));
      @(negedge clk);
      chk("t4_idle", 128'(busy), 128'(1'b0));
      stub_never = 1'b0;

      // Ready coincident with the last watchdog cycle.
      stub_lat = 15;
      msg_in[127:0] = {16{8'h12}};
      key_in[127:0] = {16{8'h21}};
      req = 2'b01;
      wait_for(1, 20, k);
      to_seen = 1'b0;
      wait_for(0, 40, k);
      chk("t5_dist", 128'(k), 128'(17));
      chk("t5_no_to", 128'(to_seen), 128'(1'b0));
      chk("t5_done", 128'(done), 128'(2'b01));
      chk("t5_result", result, {16{8'h33}});
      ack = 2'b01;
      req = 2'b00;
      @(negedge clk);
      ack = 2'b00;
      @(negedge clk);

      // Asynchronous reset while BUSY, then clean restart.
      stub_lat = 5;
      msg_in[127:0] = {16{8'h44}};
      key_in[127:0] = {16{8'h11}};
      req = 2'b01;
      wait_for(1, 20, k);
      @(negedge clk);
      @(negedge clk);
      chk("t6_busy", 128'(busy), 128'(1'b1));
      reset_n = 1'b0;
      #1;
      chk("t6_rst_busy", 128'(busy), 128'(1'b0));
      chk("t6_rst_core_reset", 128'(core_reset), 128'(1'b1));
      chk("t6_rst_pt", core_plaintext, '0);
      chk("t6_rst_result", result, '0);
      chk("t6_rst_done", 128'(done), 128'(2'b00));
      @(negedge clk);
      reset_n = 1'b1;
      wait_for(0, 50, k);
      chk("t6_latency", 128'(k), 128'(8));
      chk("t6_done", 128'(done), 128'(2'b01));
      chk("t6_result", result, {16{8'h55}});
      ack = 2'b01;
      req = 2'b00;
      @(negedge clk);
      ack = 2'b00;
      @(negedge clk);
      chk("t6_idle", 128'(busy), 128'(1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/aes_arbiter.md
Name: aes_arbiter

Overview:
- Shares one AES core among N requesters, e.g. the IO bridge and the test/diagnostic path.
- Selects a requester round-robin, latches its message and key, and sequences the core (Run, then Ready, then core reset).
- Returns the result to the granted requester over a done/ack handshake.
- Sits between the requesters and the AES core; replaces per-requester core control.

Parameters:
- N, 2, number of requesters (2..8)
- TIMEOUT, 1024, max cycles in BUSY before abort
- CW, 11, width of watchdog counter (must be ≥ clog2(TIMEOUT)+1)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  N  request per requester; held high until that requester's done
- msg_in  in  N*128  message per requester; slice i = bits [128i+127:128i]
- key_in  in  N*128  key per requester; same slicing
- ack  in  N  result consumed; sampled only for the granted index while in DELIVER
- done  out  N  one-hot; granted requester's result is valid
- result  out  128  latched core output
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  one-cycle pulse on watchdog abort
- core_reset  out  1  to core Reset; = ~reset_n OR clear_pulse
- core_run  out  1  to core Run
- core_plaintext  out  128  latched message to core
- core_key  out  128  latched key to core
- core_ciphertext  in  128  core result
- core_ready  in  1  core done flag (level)

Behaviour:
- Reset (async, reset_n low): state IDLE; rr pointer 0; grant index 0; counter 0; done 0; result 0; core_plaintext/core_key 0; core_run 0; timeout_err 0; busy 0; core_reset 1.
- States: IDLE, LAUNCH, BUSY, DELIVER, CLEAR.
- IDLE
  - If any req bit is set, pick the first set bit at or after rr_ptr, wrapping modulo N.
  - Latch grant index g, msg_in[g] → core_plaintext, key_in[g] → core_key.
  - Go to LAUNCH next cycle. With no req, stay in IDLE.
- LAUNCH
  - core_run = 1 for exactly one cycle; counter cleared.
  - Go to BUSY.
- BUSY
  - Counter increments each cycle.
  - core_ready = 1: latch core_ciphertext → result, go to DELIVER.
  - Otherwise, when counter = TIMEOUT-1: timeout_err pulse, go to CLEAR, no done.
  - core_ready and timeout on the same cycle: ready wins.
- DELIVER
  - done[g] = 1, held stable with result until ack[g] = 1.
  - Then go to CLEAR. ack on other indices is ignored.
  - done deasserts the cycle after ack is sampled.
- CLEAR
  - core_reset = 1 for one cycle.
  - rr_ptr = (g+1) mod N.
  - Go to IDLE.
- Latency: req sampled at edge 0 → core_run at cycle 1 → done no earlier than cycle 3 (1 cycle after core_ready).
- Minimum turnaround: 2 cycles after ack before the next grant.
- Inputs of the granted requester may change after the IDLE latch without effect. Requesters other than g may change freely.
- req[g] dropped mid-operation: the operation completes and done is still presented, awaiting ack.
- result is retained after CLEAR until the next DELIVER latch.
- Inputs are synchronous to clk; no CDC inside this block.

Decomposition:
- Package aes_arb_pkg:
  - state enum type (logic [2:0]: IDLE, LAUNCH, BUSY, DELIVER, CLEAR)
  - AES_W = 128
  - default TIMEOUT
- Sub-module rr_pick:
  - combinational, parameter N
  - inputs req and rr_ptr; outputs valid and index
  - unit-tested separately

Test Plan:
- Single requester 0, real core, key 000102030405060708090a0b0c0d0e0f, msg 00112233445566778899aabbccddeeff → done[0] with result 69c4e0d86a7b0430d8cdb78070b4c55a; one core_run pulse; one core_reset pulse after ack.
- req = 2'b11 held, stub core (latency 5), ack 1 cycle after each done → grants alternate 0,1,0,1; no starvation; done is always one-hot.
- Stub core never asserts ready, TIMEOUT = 16 → timeout_err pulse exactly 16 cycles after core_run; core_reset pulse; done stays 0; back to IDLE.
- ack delayed 50 cycles, msg_in[g] changed during DELIVER → result and done stable for all 50 cycles; core_plaintext unchanged.
- reset_n low during BUSY → immediate IDLE; all outputs at reset values; core_reset high; clean restart afterwards with expected result.
- Stub core_ready coincident with the counter reaching TIMEOUT-1 → DELIVER taken, timeout_err stays 0.
